// File: rtl/fifo_uart_tx_pkg.sv
// Shared encodings for the FIFO-draining UART transmitter.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read side, parity configuration and serial line of the UART transmitter.
interface fifo_uart_tx_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  empty;
  logic [DATA_WIDTH-1:0] R_data;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  R_inc;
  logic                  TX_OUT;
  logic                  Busy;

  modport master (
    output empty, R_data, PAR_EN, PAR_TYP,
    input  R_inc, TX_OUT, Busy
  );

  modport slave (
    input  empty, R_data, PAR_EN, PAR_TYP,
    output R_inc, TX_OUT, Busy
  );
endinterface

// File: rtl/fifo_uart_tx_parity_calc.sv
// Combinational parity of one data word; even = XOR of bits, odd = inverted XOR.
module tx_parity_calc
  import fifo_uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  assign par_bit = (par_typ == PAR_ODD) ? ~(^data) : (^data);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter popping words from an async FIFO read port in the TX clock domain.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic          CLK,
  input  logic          RST,
  fifo_uart_tx_if.slave bus
);

  localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  tx_state_t             state, state_d;
  logic [DATA_WIDTH-1:0] shreg, shreg_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  pop;
  logic                  par_new;

  tx_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data    (bus.R_data),
    .par_typ (bus.PAR_TYP),
    .par_bit (par_new)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= LINE_IDLE;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_d;
      shreg     <= shreg_d;
      cnt       <= cnt_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    cnt_d     = cnt;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    pop       = 1'b0;

    unique case (state)
      IDLE, STOP: begin
        if (!bus.empty) begin
          pop       = 1'b1;
          shreg_d   = bus.R_data;
          par_en_d  = bus.PAR_EN;
          par_bit_d = par_new;
          state_d   = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = DATA;
      end
      DATA: begin
        if (cnt == LAST_BIT) begin
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          cnt_d   = cnt + 1'b1;
          shreg_d = shreg >> 1;
        end
      end
      PARITY: state_d = STOP;
      default: state_d = IDLE;
    endcase

    // Line level is computed for the state being entered so TX_OUT stays registered.
    unique case (state_d)
      START:   tx_d = START_BIT;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par_bit_q;
      default: tx_d = LINE_IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign bus.R_inc  = RST & pop;
  assign bus.TX_OUT = tx_q;
  assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: FIFO modelled as a queue, each pop expands into the expected frame bits.
module tb_fifo_uart_tx;
  import fifo_uart_tx_pkg::*;

  localparam int unsigned W = 8;

  logic CLK = 1'b0;
  logic RST;

  fifo_uart_tx_if #(.DATA_WIDTH(W)) bus ();

  fifo_uart_tx #(.DATA_WIDTH(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  logic [W-1:0] fifo_q[$];
  logic         exp_q[$];
  int           pulse_cyc[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;

  assign bus.empty  = (fifo_q.size() == 0);
  assign bus.R_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;

  task automatic check(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0b want %0b at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
    end
  endtask

  // Frame = start, data LSB first, optional parity, stop.
  task automatic push_frame(input logic [W-1:0] w, input logic pe, input logic pt);
    int unsigned ones;
    ones = $countones(w);
    exp_q.push_back(1'b0);
    for (int i = 0; i < int'(W); i++) exp_q.push_back(w[i]);
    if (pe) exp_q.push_back(pt ? logic'((ones % 2) == 0) : logic'((ones % 2) == 1));
    exp_q.push_back(1'b1);
  endtask

  always @(negedge CLK) begin
    cyc++;
    if (!RST) begin
      exp_q.delete();
    end else begin
      logic want_inc;
      want_inc = !bus.empty && (exp_q.size() <= 1);
      check("r_inc", bus.R_inc, want_inc);
      check("busy", bus.Busy, exp_q.size() > 0);
      if (exp_q.size() > 0) check("tx_out", bus.TX_OUT, exp_q.pop_front());
      else                  check("tx_idle", bus.TX_OUT, 1'b1);
      if (bus.R_inc && !bus.empty) begin
        pulse_cyc.push_back(cyc);
        push_frame(fifo_q[0], bus.PAR_EN, bus.PAR_TYP);
        @(posedge CLK);
        #1;
        if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      end
    end
  end

  task automatic drain(input int limit);
    bit done;
    done = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge CLK);
      #2;
      if (fifo_q.size() == 0 && exp_q.size() == 0 && !bus.Busy) begin
        done = 1'b1;
        break;
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL drain_timeout: fifo=%0d pending_bits=%0d", fifo_q.size(), exp_q.size());
    end
  endtask

  task automatic wait_busy(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge CLK);
      #2;
      if (bus.Busy) begin
        seen = 1'b1;
        break;
      end
    end
    check("busy_seen", seen, 1'b1);
  endtask

  task automatic send_one(input logic [W-1:0] w, input logic pe, input logic pt);
    @(posedge CLK);
    #2;
    bus.PAR_EN  = pe;
    bus.PAR_TYP = pt;
    fifo_q.push_back(w);
    drain(200);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx"}, bus.TX_OUT, 1'b1);
    check({tag, "_busy"}, bus.Busy, 1'b0);
    check({tag, "_rinc"}, bus.R_inc, 1'b0);
  endtask

  initial begin
    int n0, n;
    bus.PAR_EN  = 1'b0;
    bus.PAR_TYP = PAR_EVEN;
    RST = 1'b1;
    #2 RST = 1'b0;
    #1 check_reset_outputs("por");
    repeat (2) @(posedge CLK);
    #3 RST = 1'b1;
    repeat (4) @(posedge CLK);

    send_one(8'hA5, 1'b0, PAR_EVEN);
    send_one(8'hA5, 1'b1, PAR_EVEN);
    send_one(8'hA5, 1'b1, PAR_ODD);
    send_one(8'h01, 1'b1, PAR_EVEN);

    // Back-to-back: two words queued together.
    n0 = pulse_cyc.size();
    @(posedge CLK);
    #2;
    bus.PAR_EN = 1'b0;
    fifo_q.push_back(8'h0F);
    fifo_q.push_back(8'hF0);
    drain(200);
    n = pulse_cyc.size();
    check_int("b2b_pulses", n - n0, 2);
    if (n - n0 == 2) check_int("b2b_spacing", pulse_cyc[n-1] - pulse_cyc[n-2], 10);

    // Config changed mid-frame applies only to the next word.
    @(posedge CLK);
    #2;
    bus.PAR_EN  = 1'b0;
    bus.PAR_TYP = PAR_EVEN;
    fifo_q.push_back(8'h3C);
    wait_busy(20);
    repeat (3) @(posedge CLK);
    #2;
    bus.PAR_EN  = 1'b1;
    bus.PAR_TYP = PAR_ODD;
    fifo_q.push_back(8'hC3);
    drain(200);

    // Reset in the middle of DATA.
    @(posedge CLK);
    #2;
    fifo_q.push_back(8'h5A);
    wait_busy(20);
    repeat (3) @(posedge CLK);
    #3 RST = 1'b0;
    #1 check_reset_outputs("mid");
    repeat (3) @(posedge CLK);
    #3 RST = 1'b1;
    repeat (6) @(posedge CLK);
    drain(50);

    // Random traffic with config changes at arbitrary points.
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 14)) @(posedge CLK);
      #2;
      if ($urandom_range(0, 2) == 0) begin
        bus.PAR_EN  = 1'($urandom_range(0, 1));
        bus.PAR_TYP = 1'($urandom_range(0, 1));
      end
      for (int b = 0; b < int'($urandom_range(1, 3)); b++) fifo_q.push_back(W'($urandom));
    end
    drain(5000);
    repeat (4) @(posedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

UART transmitter that drains the read side of the asynchronous FIFO in the TX clock domain. Pops one word whenever the FIFO reports non-empty, serializes it LSB-first with optional parity, and drives the serial line. Runs on the same clock as the FIFO read port, so `empty`, `R_data` and `R_inc` connect directly with no extra synchronization.

## Interface
- `DATA_WIDTH`, default 8: width of the FIFO word and the UART data field.
- `CLK`  in  1: TX clock; one serial bit per cycle.
- `RST`  in  1: reset, asynchronous, active-low.
- `empty`  in  1: FIFO read-side empty flag.
- `R_data`  in  DATA_WIDTH: FIFO read data, combinational at the current read address.
- `PAR_EN`  in  1: parity bit enable.
- `PAR_TYP`  in  1: parity type; 0 = even, 1 = odd.
- `R_inc`  out  1: FIFO pop strobe, one cycle per word.
- `TX_OUT`  out  1: serial line, idle high.
- `Busy`  out  1: high while a frame is on the line.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- **IDLE:** `TX_OUT=1`, `Busy=0`.
  - If `empty=0`: `R_inc=1` combinationally this cycle.
  - At the next edge: latch `R_data` into the shift register, latch `PAR_EN`/`PAR_TYP`, compute parity, go to START.
- **START:** `TX_OUT=0` for 1 cycle, then DATA.
- **DATA:** `DATA_WIDTH` cycles, LSB first.
  - Bit counter runs 0..DATA_WIDTH-1; after the last bit go to PARITY if the latched `PAR_EN=1`, else STOP.
- **PARITY:** 1 cycle.
  - Even: `TX_OUT` = XOR of the data bits.
  - Odd: `TX_OUT` = inverted XOR.
- **STOP:** `TX_OUT=1` for 1 cycle.
  - If `empty=0` in STOP: assert `R_inc` and load the next word, going directly to START (back-to-back frames, no idle gap).
  - Otherwise go to IDLE.
- `R_inc` is asserted only in IDLE or STOP with `empty=0`; never at any other time; never two consecutive cycles.
- `PAR_EN`/`PAR_TYP` changes mid-frame have no effect until the next load.
- `R_data` is ignored except at the load edge.

## Timing
- **Reset values:** state=IDLE, `TX_OUT=1`, `Busy=0`, `R_inc=0`, shift register=0, bit counter=0.
- **Registered outputs:** `TX_OUT` and `Busy` are registered. `Busy=1` from the first START cycle through the STOP cycle.
- **`R_inc`:** combinational decode of registered state and `empty`.
- **Latency:** `empty` falls before edge k (state IDLE) → `R_inc` high in cycle k → start bit on `TX_OUT` from edge k+1.
- **Frame length:** 1 + DATA_WIDTH + PAR_EN + 1 cycles (10 or 11 for width 8).
- **Back-to-back:** stop bit is exactly 1 cycle, and the next start bit follows immediately.
- **`empty` rising:** `empty` rising during a frame has no effect on it. STOP with `empty=1` → IDLE, `R_inc=0`.
- **Reset mid-frame:** all outputs return to reset values immediately (async); the popped word is discarded and not re-read.
- **Reset release:** deassertion is synchronized externally; first pop possible in the first cycle after release.

## Structure
- Shared package `fifo_uart_tx_pkg`:
  - state encoding localparams, binary 3-bit: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4;
  - parity type constants `PAR_EVEN=0`, `PAR_ODD=1`;
  - line level constants `LINE_IDLE=1`, `START_BIT=0`.
- Bit counter width is `$clog2(DATA_WIDTH)`.
- One sub-module, `tx_parity_calc`: combinational parity of a DATA_WIDTH word given `PAR_TYP`. Its result is registered at load time in the parent.

## Test plan
- **Reset:** `RST=0` mid-DATA → `TX_OUT=1`, `Busy=0`, `R_inc=0` immediately. After release with `empty=1`, state stays IDLE and `R_inc` stays 0.
- **No parity:** `R_data=0xA5`, `PAR_EN=0`, `empty` falls for one word → one `R_inc` pulse. `TX_OUT` = 0,1,0,1,0,0,1,0,1,1 on consecutive cycles; `Busy` high for 10 cycles.
- **Parity:** `R_data=0xA5` with `PAR_EN=1` → parity bit 0 (even) / 1 (odd), 11-cycle frame. `R_data=0x01` even parity → parity bit 1.
- **Back-to-back:** FIFO holds 0x0F, 0xF0 → exactly two `R_inc` pulses, 10 cycles apart. Second start bit immediately follows the first stop bit.
- **Latched config:** toggle `PAR_TYP` and `PAR_EN` during DATA → current frame keeps its latched config; the next frame uses the new values.
- **FIFO emptied:** FIFO empties at the end of the last word → STOP then IDLE, `TX_OUT` stays 1, no spurious `R_inc`.
